writeback_cycle: RTL and testbench
==================================

// Module: writeback_cycle
// PURPOSE
//  Final (WB) stage of the 5-stage RV32I pipeline; consumes the MEM->WB register outputs of the memory stage.
//  Selects the writeback value, drives the regfile write port and the WB->EX forwarding path, and registers
//  commit/debug info. Holds cycle/retire/control-transfer performance counters; optional commit trace FIFO.
// PARAMETERS
//  CNT_W        64  width of o_cycle_cnt / o_instret_cnt (32..64)
//  TRACE_DEPTH  8   trace FIFO entries, power of 2, >=2 (used only with WB_TRACE_EN)
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_reset_n      in   1   synchronous, active-low reset
//  i_wb_pc_add4   in   32  PC+4 of instruction in WB
//  i_wb_alu_data  in   32  ALU result
//  i_wb_ld_data   in   32  load data from LSU
//  i_wb_inst      in   32  instruction word; rd = [11:7]
//  i_wb_pc        in   32  PC of instruction in WB
//  i_wb_sel       in   2   00 ALU, 01 load, 10 PC+4, 11 zero
//  i_wb_rd_wren   in   1   regfile write request
//  i_wb_insn_vld  in   1   instruction valid (0 = bubble/flush)
//  i_wb_ctrl      in   1   instruction is branch/jump
//  i_cnt_clr      in   1   synchronous clear of all counters
//  i_trace_ready  in   1   trace consumer ready
//  o_rd_addr      out  5   regfile write address (comb)
//  o_rd_data      out  32  regfile write data / forward data (comb)
//  o_rd_wren      out  1   regfile write enable (comb)
//  o_pc_commit    out  32  PC of last committed instruction (reg)
//  o_insn_vld     out  1   commit strobe, 1 cycle after WB (reg)
//  o_cycle_cnt    out  CNT_W  cycles since reset/clear
//  o_instret_cnt  out  CNT_W  retired valid instructions
//  o_ctrl_cnt     out  32  retired control-transfer instructions
//  o_trace_valid  out  1   trace FIFO head valid
//  o_trace_data   out  69  {pc[31:0], rd[4:0], data[31:0]} at FIFO head
//  o_trace_ovf    out  1   sticky: commit dropped because FIFO full
// BEHAVIOUR
//  - Reset (i_reset_n==0 at edge): all registered outputs, counters, FIFO ptrs/count, ovf -> 0. Reset mid-traffic
//    discards FIFO contents; comb outputs still follow inputs.
//  - o_rd_data: mux per i_wb_sel; 11 -> 32'h0. o_rd_addr = i_wb_inst[11:7].
//  - o_rd_wren = i_wb_rd_wren & i_wb_insn_vld & (rd != 0); x0 never written. Zero latency (same cycle).
//  - commit = i_wb_insn_vld. Next edge: o_insn_vld <= commit; o_pc_commit <= i_wb_pc only when commit (else hold).
//  - o_cycle_cnt +1 every cycle; o_instret_cnt +1 on commit; o_ctrl_cnt +1 on commit & i_wb_ctrl.
//  - All counters wrap modulo 2^width silently. i_cnt_clr has priority over increment: counter -> 0 that edge.
//  - Counter read value is the registered value (event in cycle N visible in cycle N+1).
// CONFIGURATION
//  WB_TRACE_EN defined: TRACE_DEPTH FIFO, push on commit & o_rd_wren entry {i_wb_pc, rd, o_rd_data};
//   pop when o_trace_valid & i_trace_ready. First-word-fall-through: o_trace_data = head, valid = count!=0.
//   Full & push & no pop -> entry dropped, o_trace_ovf <= 1 (sticky until reset or i_cnt_clr).
//   Full & push & pop same cycle -> both occur, no drop. Empty & push & ready -> not bypassed (valid next cycle).
//   Pointers wrap at TRACE_DEPTH.
//  WB_TRACE_EN undefined: no FIFO storage; o_trace_valid=0, o_trace_data=0, o_trace_ovf=0; i_trace_ready ignored.
// TESTING
//  1. sel=00 alu=0x1234, rd=5, wren=1, vld=1 -> o_rd_wren=1, o_rd_addr=5, o_rd_data=0x1234 same cycle.
//  2. rd=0 wren=1 vld=1 sel=01 ld=0xDEAD -> o_rd_wren=0; vld=0 wren=1 rd=3 -> o_rd_wren=0, instret unchanged.
//  3. sel=10 pc_add4=0x108, pc=0x104, vld=1, ctrl=1 -> data=0x108; next cycle o_pc_commit=0x104,
//     o_insn_vld=1, o_ctrl_cnt=1.
//  4. 10 cycles with 6 valid commits, then i_cnt_clr=1 -> o_cycle_cnt=10, o_instret_cnt=6 before clr; all 0 after.
//     With CNT_W=32 preload via 2^32 cycles (or force) -> wraps to 0.
//  5. WB_TRACE_EN, depth 8, ready=0, 9 writing commits -> 8 entries, o_trace_ovf=1; ready=1 -> PCs in order, valid drops after 8.
//  6. Reset asserted with 3 trace entries and counters non-zero -> next cycle valid=0, counters=0, o_insn_vld=0.

Source files
------------

// File: rtl/writeback_cycle.sv
// rtl/writeback_cycle.sv - RV32I writeback stage with commit registers, perf counters and optional trace queue
//
// Final pipeline stage. Selects the register-file writeback value from the
// MEM->WB register outputs, drives the regfile write port (also used as the
// WB->EX forward path), registers commit info and keeps performance counters.
//
// Optional feature macro: WB_TRACE_EN
//   defined   : commit trace FIFO of TRACE_DEPTH entries {pc, rd, data},
//               first-word-fall-through, sticky overflow flag.
//   undefined : no trace storage; trace outputs tied to zero.
//
// Parameters
//   CNT_W        width of o_cycle_cnt / o_instret_cnt (32..64)
//   TRACE_DEPTH  trace FIFO entries, power of 2, >= 2
//
// Ports
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_wb_*             MEM->WB register outputs (pc+4, alu, load, inst, pc, sel, wren, vld, ctrl)
//   i_cnt_clr          synchronous clear of all counters and trace overflow
//   i_trace_ready      trace consumer ready
//   o_rd_addr/data/wren  regfile write port, combinational
//   o_pc_commit, o_insn_vld  registered commit info
//   o_cycle_cnt, o_instret_cnt, o_ctrl_cnt  performance counters
//   o_trace_valid, o_trace_data, o_trace_ovf  trace FIFO head and overflow

`ifdef WB_TRACE_EN
// Commit trace queue: FWFT FIFO, drops pushes when full unless a pop frees
// a slot in the same cycle.
module writeback_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 69
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_ovf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full     = (count_q == FULL_CNT);
    do_pop   = (count_q != '0) & i_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    do_push  = i_push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    ovf_d = i_clr ? 1'b0 : (ovf_q | (i_push & ~do_push));
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; count/pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_valid = (count_q != '0);
  assign o_data  = mem_q[rd_ptr_q];
  assign o_ovf   = ovf_q;
endmodule
`endif

module writeback_cycle #(
  parameter int CNT_W       = 64,
  parameter int TRACE_DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [31:0]      i_wb_pc_add4,
  input  logic [31:0]      i_wb_alu_data,
  input  logic [31:0]      i_wb_ld_data,
  input  logic [31:0]      i_wb_inst,
  input  logic [31:0]      i_wb_pc,
  input  logic [1:0]       i_wb_sel,
  input  logic             i_wb_rd_wren,
  input  logic             i_wb_insn_vld,
  input  logic             i_wb_ctrl,
  input  logic             i_cnt_clr,
  input  logic             i_trace_ready,
  output logic [4:0]       o_rd_addr,
  output logic [31:0]      o_rd_data,
  output logic             o_rd_wren,
  output logic [31:0]      o_pc_commit,
  output logic             o_insn_vld,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt,
  output logic [31:0]      o_ctrl_cnt,
  output logic             o_trace_valid,
  output logic [68:0]      o_trace_data,
  output logic             o_trace_ovf
);
  logic [4:0]       rd_addr;
  logic [31:0]      rd_data;
  logic             rd_wren;
  logic             commit;

  logic             insn_vld_q, insn_vld_d;
  logic [31:0]      pc_commit_q, pc_commit_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
  logic [31:0]      ctrl_cnt_q, ctrl_cnt_d;

  // Only the rd field of the instruction word is needed here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{i_wb_inst[31:12], i_wb_inst[6:0]};

  always_comb begin
    case (i_wb_sel)
      2'b00:   rd_data = i_wb_alu_data;
      2'b01:   rd_data = i_wb_ld_data;
      2'b10:   rd_data = i_wb_pc_add4;
      default: rd_data = 32'h0;
    endcase
    rd_addr = i_wb_inst[11:7];
    // x0 is hardwired zero: never write it, and never write for bubbles.
    rd_wren = i_wb_rd_wren & i_wb_insn_vld & (rd_addr != 5'd0);
    commit  = i_wb_insn_vld;
  end

  always_comb begin
    insn_vld_d    = commit;
    pc_commit_d   = commit ? i_wb_pc : pc_commit_q;
    // Clear wins over increment; counters wrap silently.
    cycle_cnt_d   = i_cnt_clr ? '0 : cycle_cnt_q + CNT_W'(1);
    instret_cnt_d = i_cnt_clr ? '0 : instret_cnt_q + (commit ? CNT_W'(1) : '0);
    ctrl_cnt_d    = i_cnt_clr ? '0 : ctrl_cnt_q + ((commit & i_wb_ctrl) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      insn_vld_q    <= 1'b0;
      pc_commit_q   <= '0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
      ctrl_cnt_q    <= '0;
    end else begin
      insn_vld_q    <= insn_vld_d;
      pc_commit_q   <= pc_commit_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
      ctrl_cnt_q    <= ctrl_cnt_d;
    end
  end

  assign o_rd_addr     = rd_addr;
  assign o_rd_data     = rd_data;
  assign o_rd_wren     = rd_wren;
  assign o_pc_commit   = pc_commit_q;
  assign o_insn_vld    = insn_vld_q;
  assign o_cycle_cnt   = cycle_cnt_q;
  assign o_instret_cnt = instret_cnt_q;
  assign o_ctrl_cnt    = ctrl_cnt_q;

`ifdef WB_TRACE_EN
  writeback_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .W     (69)
  ) u_trace_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (i_cnt_clr),
    .i_push    (commit & rd_wren),
    .i_data    ({i_wb_pc, rd_addr, rd_data}),
    .i_ready   (i_trace_ready),
    .o_valid   (o_trace_valid),
    .o_data    (o_trace_data),
    .o_ovf     (o_trace_ovf)
  );
`else
  logic unused_trace;
  assign unused_trace  = i_trace_ready ^ TRACE_DEPTH[0];
  assign o_trace_valid = 1'b0;
  assign o_trace_data  = '0;
  assign o_trace_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_writeback_cycle.sv
// tb/tb_writeback_cycle.sv - directed scoreboard bench for writeback_cycle
module tb_writeback_cycle;
  localparam int CNT_W = 64;
  localparam int DEPTH = 8;

  logic             clk;
  logic             rst_n;
  logic [31:0]      pc_add4, alu, ld, inst, pc;
  logic [1:0]       sel;
  logic             wren, vld, ctrl, clr, ready;
  logic [4:0]       rd_addr;
  logic [31:0]      rd_data;
  logic             rd_wren;
  logic [31:0]      pc_commit;
  logic             insn_vld;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [31:0]      ctrl_cnt;
  logic             tr_valid;
  logic [68:0]      tr_data;
  logic             tr_ovf;

  writeback_cycle #(.CNT_W(CNT_W), .TRACE_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_pc_add4(pc_add4), .i_wb_alu_data(alu), .i_wb_ld_data(ld),
    .i_wb_inst(inst), .i_wb_pc(pc), .i_wb_sel(sel),
    .i_wb_rd_wren(wren), .i_wb_insn_vld(vld), .i_wb_ctrl(ctrl),
    .i_cnt_clr(clr), .i_trace_ready(ready),
    .o_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_wren(rd_wren),
    .o_pc_commit(pc_commit), .o_insn_vld(insn_vld),
    .o_cycle_cnt(cycle_cnt), .o_instret_cnt(instret_cnt), .o_ctrl_cnt(ctrl_cnt),
    .o_trace_valid(tr_valid), .o_trace_data(tr_data), .o_trace_ovf(tr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state and scoreboards
  logic [CNT_W-1:0] m_cycle, m_instret;
  logic [31:0]      m_ctrl, m_pc;
  logic             m_vld, m_ovf;
  logic [31:0]      pc_q[$];
  logic [68:0]      tr_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
    case (sel)
      2'b00:   return alu;
      2'b01:   return ld;
      2'b10:   return pc_add4;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drv(input logic [1:0] s, input logic [31:0] a, input logic [31:0] l,
                     input logic [31:0] p4, input logic [31:0] p, input logic [4:0] rd,
                     input logic we, input logic v, input logic c);
    sel = s; alu = a; ld = l; pc_add4 = p4; pc = p;
    inst = {20'h0, rd, 7'h33}; wren = we; vld = v; ctrl = c;
  endtask

  task automatic check_comb(input string tag);
    #1;
    check({tag, "_addr"}, rd_addr, inst[11:7]);
    check({tag, "_data"}, rd_data, exp_data());
    check({tag, "_wren"}, rd_wren, wren & vld & (inst[11:7] != 5'd0));
  endtask

  // Advance one clock: update the model from the inputs present at the edge,
  // then compare every registered output after the edge.
  task automatic tick();
    logic       wr, pop, drop;
    logic [68:0] ent;
    wr = wren & vld & (inst[11:7] != 5'd0);
    ent = {pc, inst[11:7], exp_data()};
    if (!rst_n) begin
      m_cycle = '0; m_instret = '0; m_ctrl = '0; m_vld = 1'b0; m_pc = '0; m_ovf = 1'b0;
      pc_q.delete(); tr_q.delete();
    end else begin
      m_cycle   = clr ? '0 : m_cycle + 64'd1;
      m_instret = clr ? '0 : m_instret + (vld ? 64'd1 : 64'd0);
      m_ctrl    = clr ? '0 : m_ctrl + ((vld & ctrl) ? 32'd1 : 32'd0);
      m_vld     = vld;
      if (vld) pc_q.push_back(pc);
`ifdef WB_TRACE_EN
      pop  = (tr_q.size() != 0) && ready;
      drop = 1'b0;
      if (pop) void'(tr_q.pop_front());
      if (wr) begin
        if (tr_q.size() < DEPTH) tr_q.push_back(ent);
        else drop = 1'b1;
      end
      m_ovf = clr ? 1'b0 : (m_ovf | drop);
`else
      pop = 1'b0; drop = 1'b0;
`endif
    end
    @(posedge clk);
    #1;
    check("insn_vld", insn_vld, m_vld);
    if (pc_q.size() > 0) m_pc = pc_q.pop_front();
    check("pc_commit", pc_commit, m_pc);
    check("cycle_cnt", cycle_cnt, m_cycle);
    check("instret_cnt", instret_cnt, m_instret);
    check("ctrl_cnt", ctrl_cnt, m_ctrl);
    check("trace_valid", tr_valid, tr_q.size() != 0);
    check("trace_ovf", tr_ovf, m_ovf);
    if (tr_q.size() != 0) check("trace_data", tr_data, tr_q[0]);
    else check("trace_data_idle", tr_data & {69{tr_valid}}, 69'h0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; ready = 1'b1;
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic ALU writeback, same-cycle write port
    drv(2'b00, 32'h1234, 0, 0, 32'h100, 5'd5, 1, 1, 0);
    check_comb("alu");
    check("alu_const", {rd_wren, rd_addr, rd_data}, {1'b1, 5'd5, 32'h1234});
    tick();

    // x0 never written; bubble never written
    drv(2'b01, 0, 32'hDEAD, 0, 32'h104, 5'd0, 1, 1, 0);
    check_comb("x0");
    check("x0_const", {rd_wren, rd_data}, {1'b0, 32'hDEAD});
    tick();
    drv(2'b01, 0, 32'hBEEF, 0, 32'h108, 5'd3, 1, 0, 0);
    check_comb("bubble");
    tick();
    check("bubble_instret", instret_cnt, 64'd2);

    // PC+4 select on a jump
    drv(2'b10, 0, 0, 32'h108, 32'h104, 5'd7, 1, 1, 1);
    check_comb("pc4");
    tick();
    check("jump_commit", {insn_vld, pc_commit, ctrl_cnt}, {1'b1, 32'h104, 32'd1});

    // Zero select
    drv(2'b11, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'h10C, 5'd9, 1, 1, 0);
    check_comb("zero");
    tick();

    // Counters: clear, 10 cycles with 6 commits, clear again
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drv(2'b00, 32'h50 + i, 0, 0, 32'h300 + 4 * i, 5'(i + 1), 1, (i % 5) < 3, i == 1);
      tick();
    end
    check("cnt_cycle10", cycle_cnt, 64'd10);
    check("cnt_instret6", instret_cnt, 64'd6);
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("cnt_cleared", {cycle_cnt, instret_cnt, ctrl_cnt}, 160'h0);

`ifdef WB_TRACE_EN
    // Fill trace FIFO past capacity with consumer stalled
    tick(); tick();
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drv(2'b00, 32'hA00 + i, 0, 0, 32'h200 + 4 * i, 5'(i + 1), 1, 1, 0);
      tick();
    end
    check("trace_full_ovf", {tr_valid, tr_ovf}, 2'b11);
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("trace_head_pc", tr_data[68:37], 32'h200 + 4 * i);
      tick();
    end
    check("trace_drained", tr_valid, 1'b0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("trace_ovf_clr", tr_ovf, 1'b0);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(2'b00, 32'hC00 + i, 0, 0, 32'h400 + 4 * i, 5'(i + 2), 1, 1, 0);
      tick();
    end
    check("trace_three", tr_valid, 1'b1);
`else
    for (int i = 0; i < 3; i++) begin
      drv(2'b00, 32'hC00 + i, 0, 0, 32'h400 + 4 * i, 5'(i + 2), 1, 1, 0);
      tick();
    end
`endif

    // Reset mid-traffic; combinational port keeps following inputs
    rst_n = 1'b0;
    drv(2'b01, 0, 32'h5A5A, 0, 32'h500, 5'd4, 1, 1, 1);
    check_comb("rst_comb");
    tick();
    check("rst_state", {tr_valid, insn_vld, cycle_cnt, instret_cnt, ctrl_cnt}, 162'h0);
    rst_n = 1'b1;
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
